switch: RTL and testbench
=========================

Name: switch

Overview:
- 2-input / 2-output valid-ready routing switch for the engine interconnect.
- Each valid input is steered to a ready output in the same cycle; when both outputs are ready, the one with the lower downstream latency is preferred.
- Each input port is told the best (minimum) latency reachable through the switch.
- A registered round-robin pointer resolves contention between the two inputs.

Parameters:
- DWIDTH, 16, payload width in bits.
- LATENCY_COUNT_WIDTH, 5, width of the latency metric (unsigned).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- in_0_valid  in  1  input 0 carries data.
- in_0_data  in  DWIDTH  input 0 payload.
- in_0_latency  out  LATENCY_COUNT_WIDTH  best downstream latency seen from input 0.
- in_0_ready  out  1  input 0 accepted this cycle.
- in_1_valid, in_1_data, in_1_latency, in_1_ready: same as the input 0 ports, for input 1.
- out_0_valid  out  1  output 0 carries data.
- out_0_data  out  DWIDTH  output 0 payload.
- out_0_latency  in  LATENCY_COUNT_WIDTH  latency reported by the consumer behind output 0.
- out_0_ready  in  1  output 0 consumer can accept.
- out_1_valid, out_1_data, out_1_latency, out_1_ready: same as the output 0 ports, for output 1.

Behaviour:
- The datapath is purely combinational: zero-cycle latency from in_*/out_*_ready to out_*/in_*_ready. A transfer occurs at a rising clk edge when valid and ready are both high.
- out_x_valid depends combinationally on out_x_ready: a not-ready output is never driven valid.
- Preferred output:
  - out_0 if out_0_latency <= out_1_latency (tie goes to out_0), else out_1.
  - Computed from the latencies alone, regardless of ready.
- Single valid input:
  - Routed to the preferred output if that output is ready.
  - Otherwise routed to the other output if it is ready.
  - Otherwise not accepted.
- Both inputs valid:
  - The input selected by the priority pointer (prio) is routed first, using the single-input rule.
  - The other input gets the remaining ready output, if any.
- in_x_ready = 1 exactly when input x is routed this cycle; an unrouted input holds its data.
- Unused output: valid = 0, data = all zeros.
- No output is ever driven by two inputs, and no input is ever duplicated onto both outputs.
- in_0_latency = in_1_latency = min(out_0_latency, out_1_latency), combinational and independent of ready/valid (unsigned compare, no increment).
- Priority pointer (the only state):
  - prio is 1 bit; 0 means input 0 has priority.
  - Reset value: 0.
  - On a clk edge where both inputs are valid and exactly one was accepted, prio becomes the index of the losing input.
  - Otherwise prio holds.
- Reset is asynchronous and only clears prio. Combinational outputs follow their inputs even while rst is high. Asserting rst mid-operation only re-biases arbitration toward input 0.

Decomposition:
- Shared package (interconnect pkg): default DWIDTH and LATENCY_COUNT_WIDTH constants, and a latency_t typedef of LATENCY_COUNT_WIDTH bits.
- One natural sub-module, switch_arbiter, holds the prio register and grant logic. The top-level switch does the latency min/compare and the data muxing.

Test Plan:
- Latencies out_0=1, out_1=2; in_1 valid data 255; in_0 invalid; out_0_ready=0, out_1_ready=1 -> out_1_valid=1, out_1_data=255, out_0_valid=0, in_1_ready=1, in_0_latency=in_1_latency=1.
- Same inputs; out_0_ready=1, out_1_ready=0 -> out_0_valid=1, out_0_data=255, out_1_valid=0, in latencies=1.
- Same inputs; both outputs ready -> lower-latency out_0 chosen: out_0_data=255, out_0_valid=1, out_1_valid=0.
- Swap latencies (out_0=3, out_1=2), both outputs ready, in_0 valid data 33 -> out_1_data=33, in latencies=2.
- Both inputs valid (33, 255), both outputs ready, after reset (latencies out_0=1, out_1=2) -> in_0 on out_0, in_1 on out_1, both in_*_ready=1, prio unchanged.
- Contention test: both inputs valid, only out_0 ready -> cycle 1 in_0 wins (in_1_ready=0); cycle 2 in_1 wins; rst asserted mid-run -> prio back to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared interconnect definitions: default widths, latency type and
// the ready-output picker used by the switch arbiter.
package switch_pkg;

   localparam int DWIDTH_DEF  = 16;
   localparam int LATENCY_DEF = 5;

   typedef logic [LATENCY_DEF-1:0] latency_t;

   // Returns {ok, idx}: the preferred output if ready, else the other one.
   function automatic logic [1:0] route_pick(
      input logic i_pref,
      input logic i_r0,
      input logic i_r1
   );
      logic [1:0] v_res;
      v_res = 2'b00;
      if (!i_pref) begin
         if (i_r0)      v_res = 2'b10;
         else if (i_r1) v_res = 2'b11;
      end else begin
         if (i_r1)      v_res = 2'b11;
         else if (i_r0) v_res = 2'b10;
      end
      return v_res;
   endfunction

endpackage

// File: rtl/switch_arbiter.sv
// Round-robin grant logic: routes the priority input first, the other
// input takes whatever ready output is left.
module switch_arbiter
   import switch_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic i_v0,
   input  logic i_v1,
   input  logic i_r0,
   input  logic i_r1,
   input  logic i_pref,
   output logic o_g0,
   output logic o_g1,
   output logic o_d0,
   output logic o_d1
);

   logic       r_prio;
   logic       w_fv, w_sv, w_fg, w_sg, w_fd, w_sd;
   logic       w_rr0, w_rr1;
   logic [1:0] w_a, w_b;

   always_comb begin
      w_fv  = r_prio ? i_v1 : i_v0;
      w_sv  = r_prio ? i_v0 : i_v1;
      w_a   = route_pick(i_pref, i_r0, i_r1);
      w_fg  = w_fv && w_a[1];
      w_fd  = w_a[0];
      w_rr0 = i_r0 && !(w_fg && !w_fd);
      w_rr1 = i_r1 && !(w_fg && w_fd);
      w_b   = route_pick(i_pref, w_rr0, w_rr1);
      w_sg  = w_sv && w_b[1];
      w_sd  = w_b[0];
   end

   assign o_g0 = r_prio ? w_sg : w_fg;
   assign o_d0 = r_prio ? w_sd : w_fd;
   assign o_g1 = r_prio ? w_fg : w_sg;
   assign o_d1 = r_prio ? w_fd : w_sd;

   // Pointer moves to the loser so it goes first next time.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prio <= 1'b0;
      end else if (i_v0 && i_v1 && (o_g0 ^ o_g1)) begin
         r_prio <= o_g0;
      end
   end

endmodule

// File: rtl/switch.sv
// 2x2 valid/ready routing switch: latency-preferred output choice,
// combinational data muxing, round-robin contention via switch_arbiter.
module switch
   import switch_pkg::*;
#(
   parameter int DWIDTH              = DWIDTH_DEF,
   parameter int LATENCY_COUNT_WIDTH = LATENCY_DEF
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_0_valid,
   input  logic [DWIDTH-1:0]              in_0_data,
   output logic [LATENCY_COUNT_WIDTH-1:0] in_0_latency,
   output logic                           in_0_ready,
   input  logic                           in_1_valid,
   input  logic [DWIDTH-1:0]              in_1_data,
   output logic [LATENCY_COUNT_WIDTH-1:0] in_1_latency,
   output logic                           in_1_ready,
   output logic                           out_0_valid,
   output logic [DWIDTH-1:0]              out_0_data,
   input  logic [LATENCY_COUNT_WIDTH-1:0] out_0_latency,
   input  logic                           out_0_ready,
   output logic                           out_1_valid,
   output logic [DWIDTH-1:0]              out_1_data,
   input  logic [LATENCY_COUNT_WIDTH-1:0] out_1_latency,
   input  logic                           out_1_ready
);

   logic                           w_pref;
   logic                           w_g0, w_g1, w_d0, w_d1;
   logic                           w_0to0, w_1to0, w_0to1, w_1to1;
   logic [LATENCY_COUNT_WIDTH-1:0] w_min;

   assign w_pref = out_0_latency > out_1_latency;
   assign w_min  = w_pref ? out_1_latency : out_0_latency;

   assign in_0_latency = w_min;
   assign in_1_latency = w_min;

   switch_arbiter u_arb (
      .clk    (clk),
      .rst    (rst),
      .i_v0   (in_0_valid),
      .i_v1   (in_1_valid),
      .i_r0   (out_0_ready),
      .i_r1   (out_1_ready),
      .i_pref (w_pref),
      .o_g0   (w_g0),
      .o_g1   (w_g1),
      .o_d0   (w_d0),
      .o_d1   (w_d1)
   );

   assign in_0_ready = w_g0;
   assign in_1_ready = w_g1;

   assign w_0to0 = w_g0 && !w_d0;
   assign w_0to1 = w_g0 &&  w_d0;
   assign w_1to0 = w_g1 && !w_d1;
   assign w_1to1 = w_g1 &&  w_d1;

   assign out_0_valid = w_0to0 || w_1to0;
   assign out_1_valid = w_0to1 || w_1to1;

   assign out_0_data = w_0to0 ? in_0_data :
                       w_1to0 ? in_1_data : '0;
   assign out_1_data = w_0to1 ? in_0_data :
                       w_1to1 ? in_1_data : '0;

endmodule

// File: tb/tb_switch.sv
// Scoreboard bench for switch: stimulus pushes model expectations,
// a monitor pops and compares them once per cycle.
module tb_switch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_0_valid = 1'b0, in_1_valid = 1'b0;
   logic [15:0] in_0_data = '0, in_1_data = '0;
   logic [4:0]  in_0_latency, in_1_latency;
   logic        in_0_ready, in_1_ready;
   logic        out_0_valid, out_1_valid;
   logic [15:0] out_0_data, out_1_data;
   logic [4:0]  out_0_latency = '0, out_1_latency = '0;
   logic        out_0_ready = 1'b0, out_1_ready = 1'b0;

   typedef struct {
      logic        ov0, ov1;
      logic [15:0] od0, od1;
      logic        ir0, ir1;
      logic [4:0]  lat;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   mp = 0;
   bit   done = 0;

   always #5 clk = ~clk;

   switch dut (
      .clk           (clk),
      .rst           (rst),
      .in_0_valid    (in_0_valid),
      .in_0_data     (in_0_data),
      .in_0_latency  (in_0_latency),
      .in_0_ready    (in_0_ready),
      .in_1_valid    (in_1_valid),
      .in_1_data     (in_1_data),
      .in_1_latency  (in_1_latency),
      .in_1_ready    (in_1_ready),
      .out_0_valid   (out_0_valid),
      .out_0_data    (out_0_data),
      .out_0_latency (out_0_latency),
      .out_0_ready   (out_0_ready),
      .out_1_valid   (out_1_valid),
      .out_1_data    (out_1_data),
      .out_1_latency (out_1_latency),
      .out_1_ready   (out_1_ready)
   );

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, exp_v);
      end
   endtask

   task automatic drive(
      input bit v0, input int d0, input bit v1, input int d1,
      input int l0, input int l1, input bit r0, input bit r1,
      input bit rr
   );
      exp_t e;
      bit   vin[2];
      int   din[2];
      bit   rdy[2];
      bit   used[2];
      int   outord[2];
      int   inord[2];
      int   pref;
      @(posedge clk);
      #2;
      in_0_valid = v0; in_0_data = d0[15:0];
      in_1_valid = v1; in_1_data = d1[15:0];
      out_0_latency = l0[4:0]; out_1_latency = l1[4:0];
      out_0_ready = r0; out_1_ready = r1;
      rst = rr;
      if (rr) mp = 0;
      vin = '{v0, v1};
      din = '{d0 & 16'hFFFF, d1 & 16'hFFFF};
      rdy = '{r0, r1};
      used = '{0, 0};
      e = '{default: '0};
      e.lat = (l0 < l1) ? l0[4:0] : l1[4:0];
      pref = (l0 <= l1) ? 0 : 1;
      outord = '{pref, 1 - pref};
      inord = '{mp, 1 - mp};
      for (int i = 0; i < 2; i++) begin
         int k;
         k = inord[i];
         if (vin[k]) begin
            for (int j = 0; j < 2; j++) begin
               int o;
               o = outord[j];
               if (rdy[o] && !used[o]) begin
                  used[o] = 1;
                  if (o == 0) begin e.ov0 = 1; e.od0 = din[k][15:0]; end
                  else        begin e.ov1 = 1; e.od1 = din[k][15:0]; end
                  if (k == 0) e.ir0 = 1; else e.ir1 = 1;
                  break;
               end
            end
         end
      end
      if (rr) mp = 0;
      else if (v0 && v1 && (e.ir0 != e.ir1)) mp = e.ir0 ? 1 : 0;
      q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      while (!done) begin
         @(negedge clk);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("out_0_valid", int'(out_0_valid), int'(e.ov0));
            chk("out_0_data", int'(out_0_data), int'(e.od0));
            chk("out_1_valid", int'(out_1_valid), int'(e.ov1));
            chk("out_1_data", int'(out_1_data), int'(e.od1));
            chk("in_0_ready", int'(in_0_ready), int'(e.ir0));
            chk("in_1_ready", int'(in_1_ready), int'(e.ir1));
            chk("in_0_latency", int'(in_0_latency), int'(e.lat));
            chk("in_1_latency", int'(in_1_latency), int'(e.lat));
         end
      end
   end

   initial begin : stim
      drive(0, 0, 0, 0, 1, 2, 0, 0, 1);
      drive(0, 0, 1, 255, 1, 2, 0, 1, 0);
      drive(0, 0, 1, 255, 1, 2, 1, 0, 0);
      drive(0, 0, 1, 255, 1, 2, 1, 1, 0);
      drive(1, 33, 0, 0, 3, 2, 1, 1, 0);
      drive(1, 33, 1, 255, 1, 2, 1, 1, 0);
      drive(1, 33, 1, 255, 1, 2, 1, 0, 0);
      drive(1, 33, 1, 255, 1, 2, 1, 0, 0);
      drive(1, 33, 1, 255, 1, 2, 1, 0, 0);
      drive(1, 33, 1, 255, 1, 2, 1, 0, 1);
      drive(1, 33, 1, 255, 1, 2, 1, 0, 0);
      drive(1, 33, 1, 255, 2, 2, 0, 1, 0);
      drive(1, 33, 1, 255, 31, 0, 1, 1, 0);
      for (int n = 0; n < 400; n++) begin
         drive($urandom_range(0, 1), int'($urandom_range(0, 65535)),
               $urandom_range(0, 1), int'($urandom_range(0, 65535)),
               int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
               $urandom_range(0, 1), $urandom_range(0, 1),
               ($urandom_range(0, 39) == 0));
      end
      repeat (3) @(posedge clk);
      chk("queue_drained", q.size(), 0);
      done = 1;
      @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
